// File: rtl/exprom_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | exprom_pkg                                                           |
// | Shared state encoding and byte-enable constants for exprom_ctrl.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package exprom_pkg;

  localparam int EXPROM_ADDR_W = 9;

  localparam logic [3:0] BE_NONE = 4'b1111;
  localparam logic [3:0] BE_ALL  = 4'b0000;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    RD_WAIT = 3'd2,
    MERGE   = 3'd3,
    WR      = 3'd4,
    ACK     = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/exprom_byte_merge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | exprom_byte_merge                                                    |
// | Lane-wise select of new write data over stored data (be_n low=new).  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module exprom_byte_merge (
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  input  logic [3:0]  i_be_n,
  output logic [31:0] o_data
);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign o_data[8*i +: 8] = i_be_n[i] ? i_rdata[8*i +: 8] : i_wdata[8*i +: 8];
  end

endmodule
`default_nettype wire

// File: rtl/exprom_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | exprom_ctrl                                                          |
// | PCI expansion-ROM target controller; writes need EXPROM_WRITE_EN.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module exprom_ctrl
  import exprom_pkg::*;
#(
  parameter int ADDR_W = EXPROM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [3:0]        be_n,
  output logic              ack,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] rom_address,
  output logic              rom_enable,
  output logic              rom_wren,
  output logic [31:0]       rom_dinp,
  input  logic [31:0]       rom_dout
);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_rdata;

`ifdef EXPROM_WRITE_EN
  logic        r_wr;
  logic [3:0]  r_be_n;
  logic [31:0] r_dinp;
  logic [31:0] w_merged;

  // r_dinp carries the write data until MERGE overwrites it with the merged word
  exprom_byte_merge u_merge (
    .i_wdata (r_dinp),
    .i_rdata (rom_dout),
    .i_be_n  (r_be_n),
    .o_data  (w_merged)
  );
`else
  logic w_unused;
  assign w_unused = ^{wdata, be_n};
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (req) begin
`ifdef EXPROM_WRITE_EN
          if (!wr)                   w_next = RD;
          else if (be_n == BE_NONE)  w_next = ACK;
          else if (be_n == BE_ALL)   w_next = WR;
          else                       w_next = RD;
`else
          w_next = wr ? ACK : RD;
`endif
        end
      end
`ifdef EXPROM_WRITE_EN
      RD:      w_next = r_wr ? MERGE : RD_WAIT;
      MERGE:   w_next = WR;
      WR:      w_next = ACK;
`else
      RD:      w_next = RD_WAIT;
`endif
      RD_WAIT: w_next = ACK;
      ACK:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_rdata <= '0;
`ifdef EXPROM_WRITE_EN
      r_wr    <= 1'b0;
      r_be_n  <= BE_NONE;
      r_dinp  <= '0;
`endif
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && req) begin
        r_addr <= addr;
`ifdef EXPROM_WRITE_EN
        r_wr   <= wr;
        r_be_n <= be_n;
        r_dinp <= wdata;
`endif
      end
      if (r_state == RD_WAIT) r_rdata <= rom_dout;
`ifdef EXPROM_WRITE_EN
      if (r_state == MERGE) r_dinp <= w_merged;
`endif
    end
  end

  assign ack         = (r_state == ACK);
  assign busy        = (r_state != IDLE);
  assign rdata       = r_rdata;
  assign rom_address = r_addr;

`ifdef EXPROM_WRITE_EN
  assign rom_enable  = (r_state == RD) || (r_state == WR);
  assign rom_wren    = (r_state == WR);
  assign rom_dinp    = r_dinp;
`else
  assign rom_enable  = (r_state == RD);
  assign rom_wren    = 1'b0;
  assign rom_dinp    = '0;
`endif

endmodule
`default_nettype wire

// File: doc/exprom_ctrl.md
EXPROM_CTRL -- requirements
Module: exprom_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 9: ROM word-address width (512 x 32-bit words).
REQ-002 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port req, input, 1: PCI-target access request; held high until ack.
REQ-005 SHALL have port wr, input, 1: 1 = write, 0 = read; valid while req is high.
REQ-006 SHALL have port addr, input, ADDR_W: word address within the expansion-ROM window.
REQ-007 SHALL have port wdata, input, 32: write data.
REQ-008 SHALL have port be_n, input, 4: PCI byte enables, active low, with bit i covering byte i.
REQ-009 SHALL have port ack, output, 1: one-cycle completion pulse.
REQ-010 SHALL have port rdata, output, 32: read data, valid in the ack cycle of a read.
REQ-011 SHALL have port busy, output, 1: high whenever the FSM is not IDLE.
REQ-012 SHALL have ports rom_address (output, ADDR_W), rom_enable (output, 1), rom_wren (output, 1), rom_dinp (output, 32) and rom_dout (input, 32): storage side; storage has one-cycle synchronous read and a single write enable for all four lanes.

Function
REQ-013 SHALL implement FSM states IDLE, RD, RD_WAIT, MERGE, WR and ACK.
REQ-014 SHALL sample req only in IDLE; cycle N is the cycle in which req is sampled high.
REQ-015 SHALL register addr, wr, wdata and be_n at the end of cycle N; later input changes SHALL be ignored until ACK.
REQ-016 Read: rom_enable=1 and rom_address=addr in N+1; rom_dout captured into rdata at the end of N+2; ack=1 in N+3.
REQ-017 Full write (be_n=4'b0000): rom_enable=1, rom_wren=1, rom_dinp=wdata in N+1; ack in N+2; no read cycle.
REQ-018 Partial write (be_n neither 4'b0000 nor 4'b1111): read as in REQ-016; merge registered at the end of N+2 (byte i = wdata byte i if be_n[i]=0, else rom_dout byte i); rom_wren=1 with the merged data in N+3; ack in N+4.
REQ-019 Null write (be_n=4'b1111): no ROM access; ack in N+1.
REQ-020 Read SHALL ignore be_n and always return all 32 bits.
REQ-021 ACK SHALL last exactly one cycle and then go to IDLE unconditionally; req is not sampled in ACK, so the earliest next acceptance is the cycle after ack.
REQ-022 rom_wren SHALL be high only in WR and for exactly one cycle per write; rom_enable SHALL be high only in RD and WR.
REQ-023 rdata SHALL hold its last read value until the next read capture; writes SHALL not change it.
REQ-024 addr SHALL be used modulo 2^ADDR_W without range checking.

Reset
REQ-025 On rst_n low, asynchronously: state=IDLE; ack, busy, rom_enable and rom_wren = 0; rom_address=0; rom_dinp=0; rdata=0.
REQ-026 Reset during any state SHALL abort the access without ack; a pending partial write SHALL not reach the ROM.
REQ-027 The first req SHALL be accepted no earlier than the first clk edge after rst_n deasserts.

Configuration
REQ-028 Macro EXPROM_WRITE_EN: when defined, writes behave per REQ-017..REQ-019.
REQ-029 When EXPROM_WRITE_EN is undefined, every write SHALL be acked in N+1 with no ROM access, rom_wren tied 0, rom_dinp tied 0, and the MERGE/WR logic absent; reads are unchanged.

Structure
REQ-030 Package exprom_pkg SHALL hold the FSM state enum, the ADDR_W default and the BE_NONE (4'b1111) and BE_ALL (4'b0000) constants.
REQ-031 Byte merging SHALL live in sub-module exprom_byte_merge (combinational, 32-bit, be_n-driven), instantiated only under EXPROM_WRITE_EN.

Verification
REQ-032 Preload word 0x010 with 0xAA55_1234; read addr=0x010 -> ack in N+3, rdata=0xAA55_1234, one rom_enable pulse, no rom_wren.
REQ-033 Word 0x020 = 0x1122_3344; write wdata=0xDEAD_BEEF, be_n=4'b1010 -> rom_wren in N+3 with rom_dinp=0x11AD_33EF, ack in N+4; a readback returns 0x11AD_33EF.
REQ-034 Write be_n=4'b0000, wdata=0xCAFE_F00D to 0x1FF -> rom_wren in N+1, ack in N+2; write be_n=4'b1111 -> ack in N+1, no ROM activity.
REQ-035 Back-to-back reads, req held high through ack -> second acceptance in the cycle after ack; exactly one ack per access.
REQ-036 Assert rst_n low in MERGE of a partial write -> no rom_wren, no ack, all outputs 0; the target word is unchanged.
REQ-037 Build without EXPROM_WRITE_EN; write 0x1234_5678 to 0x005 -> ack in N+1, rom_wren never high; readback returns the preloaded value.
